axi2apb_bus0_bridge: RTL and testbench

//  AXI4 slave to APB master bridge on slave port of the bus0 interconnect; sole path to low-speed peripherals.

---
 rtl/axi2apb_bus0_bridge_pkg.sv | 51 +++++
 rtl/types_bus0_pkg.sv | 80 ++++++++
 rtl/axi2apb_bus0_bridge.sv | 142 ++++++++++++++
 tb/tb_axi2apb_bus0_bridge.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2apb_bus0_bridge_pkg.sv
// Bridge-private state: FSM encoding, the register bundle with its reset
// value, and the per-beat AXI address step (kept inside one 4 KB page).
package axi2apb_bus0_bridge_pkg;
  import types_bus0_pkg::*;

  typedef enum logic [2:0] {IDLE, W_WAIT, SETUP, ACCESS, R_OUT, B_OUT} state_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    state_t                          state;
    logic [31:0]                     addr;
    logic [7:0]                      len;
    logic [2:0]                      size;
    logic [1:0]                      burst;
    logic [2:0]                      prot;
    logic [CFG_SYSBUS_ID_BITS-1:0]   id;
    logic [CFG_SYSBUS_USER_BITS-1:0] user;
    logic                            write;
    logic [7:0]                      cnt;
    logic                            half;
    logic                            err;
    logic [63:0]                     wdata;
    logic [7:0]                      wstrb;
    logic [63:0]                     rdata;
  } axi2apb_registers;

  localparam axi2apb_registers axi2apb_r_reset = '{state: IDLE, default: '0};

  function automatic logic [11:0] next_addr(input logic [2:0]  size,
                                            input logic [1:0]  burst,
                                            input logic [7:0]  len,
                                            input logic [11:0] addr);
    logic [11:0] incr;
    logic [15:0] wrap_bytes;
    logic [11:0] mask;
    incr       = 12'd1 << size;
    wrap_bytes = ({8'd0, len} + 16'd1) << size;
    mask       = wrap_bytes[11:0] - 12'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + incr) & mask);
      default:     next_addr = addr + incr;
    endcase
  endfunction

endpackage

// File: rtl/types_bus0_pkg.sv
// Shared bus0 types: AXI4 slave-side and APB channel bundles, PnP descriptor
// and the constants identifying the APB bridge slot on the interconnect.
package types_bus0_pkg;

  localparam int CFG_SYSBUS_ID_BITS   = 5;
  localparam int CFG_SYSBUS_USER_BITS = 1;

  localparam int          CFG_BUS0_XSLV_APB       = 7;
  localparam logic [15:0] VENDOR_OPTIMITI         = 16'h00F1;
  localparam logic [15:0] OPTIMITI_AXI2APB_BRIDGE = 16'h0208;
  localparam logic [63:0] CFG_BUS0_APB_ADDR_START = 64'h0000_0000_1000_0000;
  localparam logic [63:0] CFG_BUS0_APB_ADDR_END   = 64'h0000_0000_1010_0000;

  typedef struct packed {
    logic [7:0]  xindex;
    logic [15:0] vid;
    logic [15:0] did;
    logic [63:0] addr_start;
    logic [63:0] addr_end;
  } dev_config_type;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  prot;
  } axi4_metadata_type;

  typedef struct packed {
    logic                            aw_valid;
    axi4_metadata_type               aw_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]   aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] aw_user;
    logic                            w_valid;
    logic [63:0]                     w_data;
    logic                            w_last;
    logic [7:0]                      w_strb;
    logic [CFG_SYSBUS_USER_BITS-1:0] w_user;
    logic                            b_ready;
    logic                            ar_valid;
    axi4_metadata_type               ar_bits;
    logic [CFG_SYSBUS_ID_BITS-1:0]   ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] ar_user;
    logic                            r_ready;
  } axi4_slave_in_type;

  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic [CFG_SYSBUS_ID_BITS-1:0]   b_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] b_user;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [63:0]                     r_data;
    logic                            r_last;
    logic [CFG_SYSBUS_ID_BITS-1:0]   r_id;
    logic [CFG_SYSBUS_USER_BITS-1:0] r_user;
  } axi4_slave_out_type;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel;
    logic        penable;
    logic [2:0]  pprot;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;

endpackage

// File: rtl/axi2apb_bus0_bridge.sv
// AXI4 slave to APB master bridge: one burst at a time, each 64-bit beat is
// carried as one APB transfer (size<3) or two 32-bit halves (size=3).
module axi2apb_bus0_bridge
  import types_bus0_pkg::*;
  import axi2apb_bus0_bridge_pkg::*;
#(
  parameter int hindex = 0,
  parameter int APB_AW = 32
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  output dev_config_type     o_cfg,
  input  axi4_slave_in_type  i_xslvi,
  output axi4_slave_out_type o_xslvo,
  output apb_in_type         o_apbo,
  input  apb_out_type        i_apbi
);

  localparam logic [31:0] PADDR_MASK = 32'hFFFF_FFFF >> (32 - APB_AW);

  axi2apb_registers                r;
  axi4_metadata_type               req;
  logic [CFG_SYSBUS_ID_BITS-1:0]   req_id;
  logic [CFG_SYSBUS_USER_BITS-1:0] req_user;
  logic                            lane;
  logic                            unused_in;

  // Reads win arbitration, so the request mux follows ar_valid.
  assign req      = i_xslvi.ar_valid ? i_xslvi.ar_bits : i_xslvi.aw_bits;
  assign req_id   = i_xslvi.ar_valid ? i_xslvi.ar_id   : i_xslvi.aw_id;
  assign req_user = i_xslvi.ar_valid ? i_xslvi.ar_user : i_xslvi.aw_user;
  assign lane     = (r.size == 3'd3) ? r.half : r.addr[2];
  assign unused_in = ^{req.addr[63:32], i_xslvi.w_user};

  assign o_cfg = '{xindex:     8'(hindex),
                   vid:        VENDOR_OPTIMITI,
                   did:        OPTIMITI_AXI2APB_BRIDGE,
                   addr_start: CFG_BUS0_APB_ADDR_START,
                   addr_end:   CFG_BUS0_APB_ADDR_END};

  // NOTE: synchronous reset and non-blocking assignments only, so every field of r updates together on the edge.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r <= axi2apb_r_reset;
    end else begin
      case (r.state)
        IDLE: begin
          if (i_xslvi.ar_valid || i_xslvi.aw_valid) begin
            r.state <= i_xslvi.ar_valid ? SETUP : W_WAIT;
            r.write <= !i_xslvi.ar_valid;
            r.addr  <= req.addr[31:0];
            r.len   <= req.len;
            r.size  <= req.size;
            r.burst <= req.burst;
            r.prot  <= req.prot;
            r.id    <= req_id;
            r.user  <= req_user;
            r.cnt   <= req.len;
            r.half  <= 1'b0;
            r.err   <= 1'b0;
          end
        end
        W_WAIT: begin
          if (i_xslvi.w_valid) begin
            r.wdata <= i_xslvi.w_data;
            r.wstrb <= i_xslvi.w_strb;
            // A wlast that disagrees with the beat count poisons the whole burst.
            r.err   <= r.err | (i_xslvi.w_last != (r.cnt == 8'd0));
            r.state <= SETUP;
          end
        end
        SETUP: r.state <= ACCESS;
        ACCESS: begin
          if (i_apbi.pready) begin
            r.err <= r.err | i_apbi.pslverr;
            if (!r.write) begin
              if (r.size == 3'd3 && r.half) r.rdata[63:32] <= i_apbi.prdata;
              else if (lane)                r.rdata <= {i_apbi.prdata, 32'h0};
              else                          r.rdata <= {32'h0, i_apbi.prdata};
            end
            if (r.size == 3'd3 && !r.half) begin
              r.half  <= 1'b1;
              r.state <= SETUP;
            end else begin
              r.half       <= 1'b0;
              r.addr[11:0] <= next_addr(r.size, r.burst, r.len, r.addr[11:0]);
              if (!r.write) begin
                r.state <= R_OUT;
              end else if (r.cnt == 8'd0) begin
                r.state <= B_OUT;
              end else begin
                r.cnt   <= r.cnt - 8'd1;
                r.state <= W_WAIT;
              end
            end
          end
        end
        R_OUT: begin
          if (i_xslvi.r_ready) begin
            r.err <= 1'b0;
            if (r.cnt == 8'd0) begin
              r.state <= IDLE;
            end else begin
              r.cnt   <= r.cnt - 8'd1;
              r.state <= SETUP;
            end
          end
        end
        B_OUT: if (i_xslvi.b_ready) r.state <= IDLE;
        default: r.state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    o_xslvo          = '0;
    o_xslvo.ar_ready = (r.state == IDLE);
    o_xslvo.aw_ready = (r.state == IDLE) && !i_xslvi.ar_valid;
    o_xslvo.w_ready  = (r.state == W_WAIT);
    o_xslvo.r_valid  = (r.state == R_OUT);
    o_xslvo.r_data   = r.rdata;
    o_xslvo.r_resp   = r.err ? RESP_SLVERR : RESP_OKAY;
    o_xslvo.r_last   = (r.cnt == 8'd0);
    o_xslvo.r_id     = r.id;
    o_xslvo.r_user   = r.user;
    o_xslvo.b_valid  = (r.state == B_OUT);
    o_xslvo.b_resp   = r.err ? RESP_SLVERR : RESP_OKAY;
    o_xslvo.b_id     = r.id;
    o_xslvo.b_user   = r.user;

    o_apbo         = '0;
    o_apbo.paddr   = ((r.size == 3'd3) ? {r.addr[31:3], r.half, 2'b00} : r.addr) & PADDR_MASK;
    o_apbo.pwrite  = r.write;
    o_apbo.pwdata  = lane ? r.wdata[63:32] : r.wdata[31:0];
    o_apbo.pstrb   = lane ? r.wstrb[7:4]   : r.wstrb[3:0];
    o_apbo.psel    = (r.state == SETUP) || (r.state == ACCESS);
    o_apbo.penable = (r.state == ACCESS);
    o_apbo.pprot   = r.prot;
  end

endmodule

// File: tb/tb_axi2apb_bus0_bridge.sv
// Directed bench for the AXI4-to-APB bridge: table of single-beat reads plus
// hand sequences for bursts, errors, arbitration, back-pressure and reset.
`timescale 1ns/1ps
module tb_axi2apb_bus0_bridge;
  import types_bus0_pkg::*;
  import axi2apb_bus0_bridge_pkg::*;

  logic               clk = 1'b0;
  logic               nrst;
  dev_config_type     cfg;
  axi4_slave_in_type  xslvi;
  axi4_slave_out_type xslvo;
  apb_in_type         apbo;
  apb_out_type        apbi;

  always #5 clk = ~clk;

  axi2apb_bus0_bridge #(.hindex(0), .APB_AW(32)) dut (
    .i_clk(clk), .i_nrst(nrst), .o_cfg(cfg),
    .i_xslvi(xslvi), .o_xslvo(xslvo), .o_apbo(apbo), .i_apbi(apbi)
  );

  // APB slave model: read data is {paddr[15:0], ~paddr[15:0]} unless a constant is forced.
  logic        pready_en;
  logic        rd_const_mode;
  logic [31:0] rd_const;
  logic [31:0] err_addr;
  always_comb begin
    apbi.pready  = pready_en;
    apbi.prdata  = rd_const_mode ? rd_const : {apbo.paddr[15:0], ~apbo.paddr[15:0]};
    apbi.pslverr = apbo.psel && apbo.penable && (apbo.paddr == err_addr);
  end

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } apb_xfer_t;
  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [4:0]  id;
  } rbeat_t;
  typedef struct packed {
    logic [1:0] resp;
    logic [4:0] id;
  } bbeat_t;

  apb_xfer_t apb_log[$];
  rbeat_t    rq[$];
  bbeat_t    bq[$];

  always @(posedge clk) begin
    if (nrst && apbo.psel && apbo.penable && apbi.pready)
      apb_log.push_back('{apbo.paddr, apbo.pwrite, apbo.pwdata, apbo.pstrb});
    if (nrst && xslvo.r_valid && xslvi.r_ready)
      rq.push_back('{xslvo.r_data, xslvo.r_resp, xslvo.r_last, xslvo.r_id});
    if (nrst && xslvo.b_valid && xslvi.b_ready)
      bq.push_back('{xslvo.b_resp, xslvo.b_id});
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, expected handshake", name);
  endtask

  task automatic drive_ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [4:0] id);
    xslvi.ar_valid = 1'b1;
    xslvi.ar_bits  = '{addr: a, len: l, size: s, burst: b, prot: 3'd1};
    xslvi.ar_id    = id;
  endtask

  task automatic drive_aw(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [4:0] id);
    xslvi.aw_valid = 1'b1;
    xslvi.aw_bits  = '{addr: a, len: l, size: s, burst: b, prot: 3'd1};
    xslvi.aw_id    = id;
  endtask

  task automatic send_ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [4:0] id);
    int t = 0;
    drive_ar(a, l, s, b, id);
    while (!xslvo.ar_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("ar handshake");
    @(negedge clk);
    xslvi.ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [4:0] id);
    int t = 0;
    drive_aw(a, l, s, b, id);
    while (!xslvo.aw_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("aw handshake");
    @(negedge clk);
    xslvi.aw_valid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] strb, input logic last);
    int t = 0;
    xslvi.w_valid = 1'b1;
    xslvi.w_data  = d;
    xslvi.w_strb  = strb;
    xslvi.w_last  = last;
    while (!xslvo.w_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("w handshake");
    @(negedge clk);
    xslvi.w_valid = 1'b0;
  endtask

  task automatic wait_r(input int n, input string name);
    int t = 0;
    while (rq.size() < n && t < 500) begin @(negedge clk); t++; end
    if (rq.size() < n) timeout(name);
  endtask

  task automatic wait_b(input string name);
    int t = 0;
    while (bq.size() < 1 && t < 500) begin @(negedge clk); t++; end
    if (bq.size() < 1) timeout(name);
  endtask

  task automatic check_xfer(input string name, input int i, input logic [31:0] a,
                            input logic w, input logic [31:0] d, input logic [3:0] s);
    if (i >= apb_log.size()) begin
      timeout(name);
    end else begin
      check({name, " paddr"}, 64'(apb_log[i].addr), 64'(a));
      check({name, " pwrite"}, 64'(apb_log[i].write), 64'(w));
      if (w) begin
        check({name, " pwdata"}, 64'(apb_log[i].wdata), 64'(d));
        check({name, " pstrb"}, 64'(apb_log[i].strb), 64'(s));
      end
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  size;
    int          nxfer;
    logic [31:0] paddr0;
    logic [63:0] rdata;
  } rd_vec_t;
  rd_vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int early;
    int t;
    logic stable;
    logic [63:0] d0;
    int n0;
    logic [31:0] wrap_addr [8];

    vecs[0] = '{addr: 64'h1000,                size: 3'd2, nxfer: 1, paddr0: 32'h0000_1000, rdata: 64'h0000_0000_1000_EFFF};
    vecs[1] = '{addr: 64'h1004,                size: 3'd2, nxfer: 1, paddr0: 32'h0000_1004, rdata: 64'h1004_EFFB_0000_0000};
    vecs[2] = '{addr: 64'h1008,                size: 3'd3, nxfer: 2, paddr0: 32'h0000_1008, rdata: 64'h100C_EFF3_1008_EFF7};
    vecs[3] = '{addr: 64'h1000_0ABC,           size: 3'd2, nxfer: 1, paddr0: 32'h1000_0ABC, rdata: 64'h0ABC_F543_0000_0000};
    vecs[4] = '{addr: 64'h07F4,                size: 3'd3, nxfer: 2, paddr0: 32'h0000_07F0, rdata: 64'h07F4_F80B_07F0_F80F};
    vecs[5] = '{addr: 64'hFFFF_0000_0000_2010, size: 3'd2, nxfer: 1, paddr0: 32'h0000_2010, rdata: 64'h0000_0000_2010_DFEF};
    wrap_addr = '{32'h1018, 32'h101C, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010, 32'h1014};

    xslvi = '0;
    xslvi.r_ready = 1'b1;
    xslvi.b_ready = 1'b1;
    pready_en     = 1'b1;
    rd_const_mode = 1'b0;
    rd_const      = 32'h0;
    err_addr      = 32'hFFFF_FFFF;
    nrst          = 1'b0;
    repeat (3) @(negedge clk);

    check("reset ar_ready", 64'(xslvo.ar_ready), 64'd1);
    check("reset w_ready", 64'(xslvo.w_ready), 64'd0);
    check("reset r_valid", 64'(xslvo.r_valid), 64'd0);
    check("reset b_valid", 64'(xslvo.b_valid), 64'd0);
    check("reset psel", 64'(apbo.psel), 64'd0);
    check("reset penable", 64'(apbo.penable), 64'd0);
    check("reset r_data", xslvo.r_data, 64'd0);
    check("cfg vid", 64'(cfg.vid), 64'h00F1);
    check("cfg did", 64'(cfg.did), 64'h0208);
    nrst = 1'b1;
    @(negedge clk);

    // Single 32-bit read, zero-wait APB: r_valid three cycles after the AR cycle.
    rd_const_mode = 1'b1;
    rd_const      = 32'hA5A5_A5A5;
    apb_log.delete(); rq.delete();
    drive_ar(64'h1000, 8'd0, 3'd2, BURST_INCR, 5'd3);
    @(negedge clk);
    xslvi.ar_valid = 1'b0;
    lat = 1;
    while (!xslvo.r_valid && lat < 50) begin @(negedge clk); lat++; end
    check("rd32 latency", 64'(lat), 64'd3);
    check("rd32 r_data", xslvo.r_data, 64'h0000_0000_A5A5_A5A5);
    check("rd32 r_resp", 64'(xslvo.r_resp), 64'd0);
    check("rd32 r_last", 64'(xslvo.r_last), 64'd1);
    check("rd32 r_id", 64'(xslvo.r_id), 64'd3);
    @(negedge clk);
    check("rd32 apb count", 64'(apb_log.size()), 64'd1);
    check_xfer("rd32 xfer", 0, 32'h1000, 1'b0, 32'h0, 4'h0);

    // 64-bit beat: two APB transfers add two cycles.
    drive_ar(64'h1008, 8'd0, 3'd3, BURST_INCR, 5'd4);
    @(negedge clk);
    xslvi.ar_valid = 1'b0;
    lat = 1;
    while (!xslvo.r_valid && lat < 50) begin @(negedge clk); lat++; end
    check("rd64 latency", 64'(lat), 64'd5);
    check("rd64 r_data", xslvo.r_data, 64'hA5A5_A5A5_A5A5_A5A5);
    @(negedge clk);

    // Table of single-beat reads with an address-derived APB read pattern.
    rd_const_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      apb_log.delete(); rq.delete();
      send_ar(vecs[i].addr, 8'd0, vecs[i].size, BURST_INCR, 5'(i));
      wait_r(1, $sformatf("vec%0d r beat", i));
      check($sformatf("vec%0d r_data", i), rq[0].data, vecs[i].rdata);
      check($sformatf("vec%0d r_resp", i), 64'(rq[0].resp), 64'd0);
      check($sformatf("vec%0d r_last", i), 64'(rq[0].last), 64'd1);
      check($sformatf("vec%0d apb count", i), 64'(apb_log.size()), 64'(vecs[i].nxfer));
      check_xfer($sformatf("vec%0d first xfer", i), 0, vecs[i].paddr0, 1'b0, 32'h0, 4'h0);
    end

    // Two-beat 64-bit write burst.
    apb_log.delete(); bq.delete();
    send_aw(64'h2000, 8'd1, 3'd3, BURST_INCR, 5'd7);
    send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    send_w(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    wait_b("wr64 b beat");
    check("wr64 b_resp", 64'(bq[0].resp), 64'd0);
    check("wr64 b_id", 64'(bq[0].id), 64'd7);
    check("wr64 apb count", 64'(apb_log.size()), 64'd4);
    check_xfer("wr64 xfer0", 0, 32'h2000, 1'b1, 32'h3333_4444, 4'hF);
    check_xfer("wr64 xfer1", 1, 32'h2004, 1'b1, 32'h1111_2222, 4'hF);
    check_xfer("wr64 xfer2", 2, 32'h2008, 1'b1, 32'h7777_8888, 4'hF);
    check_xfer("wr64 xfer3", 3, 32'h200C, 1'b1, 32'h5555_6666, 4'hF);

    // pslverr on the upper half of the first beat only.
    rq.delete();
    err_addr = 32'h3004;
    send_ar(64'h3000, 8'd1, 3'd3, BURST_INCR, 5'd1);
    wait_r(2, "slverr r beats");
    check("slverr beat0 r_resp", 64'(rq[0].resp), 64'd2);
    check("slverr beat1 r_resp", 64'(rq[1].resp), 64'd0);
    check("slverr beat0 r_last", 64'(rq[0].last), 64'd0);
    check("slverr beat1 r_last", 64'(rq[1].last), 64'd1);
    check("slverr beat1 r_data", rq[1].data, 64'h300C_CFF3_3008_CFF7);
    err_addr = 32'hFFFF_FFFF;

    // AR and AW together: read goes first, AW stalls until the read is done.
    apb_log.delete(); rq.delete(); bq.delete();
    drive_ar(64'h6000, 8'd0, 3'd2, BURST_INCR, 5'd2);
    drive_aw(64'h6100, 8'd0, 3'd2, BURST_INCR, 5'd9);
    #1;
    check("prio aw_ready", 64'(xslvo.aw_ready), 64'd0);
    check("prio ar_ready", 64'(xslvo.ar_ready), 64'd1);
    @(negedge clk);
    xslvi.ar_valid = 1'b0;
    early = 0;
    t = 0;
    while (rq.size() == 0 && t < 100) begin
      if (xslvo.aw_ready) early++;
      @(negedge clk);
      t++;
    end
    if (rq.size() == 0) timeout("prio r beat");
    check("prio aw_ready during read", 64'(early), 64'd0);
    t = 0;
    while (!xslvo.aw_ready && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    xslvi.aw_valid = 1'b0;
    send_w(64'h0000_0000_CAFE_F00D, 8'h0F, 1'b1);
    wait_b("prio b beat");
    check("prio apb count", 64'(apb_log.size()), 64'd2);
    check_xfer("prio read xfer", 0, 32'h6000, 1'b0, 32'h0, 4'h0);
    check_xfer("prio write xfer", 1, 32'h6100, 1'b1, 32'hCAFE_F00D, 4'hF);

    // WRAP burst: 32-byte window starting mid-window.
    apb_log.delete(); rq.delete();
    send_ar(64'h1018, 8'd3, 3'd3, BURST_WRAP, 5'd5);
    wait_r(4, "wrap r beats");
    check("wrap apb count", 64'(apb_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      check_xfer($sformatf("wrap xfer%0d", i), i, wrap_addr[i], 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap beat%0d r_last", i), 64'(rq[i].last), (i == 3) ? 64'd1 : 64'd0);
    check("wrap beat1 r_data", rq[1].data, 64'h1004_EFFB_1000_EFFF);

    // r_ready held low: R beat frozen and no further APB traffic.
    apb_log.delete(); rq.delete();
    xslvi.r_ready = 1'b0;
    send_ar(64'h4000, 8'd1, 3'd2, BURST_INCR, 5'd6);
    t = 0;
    while (!xslvo.r_valid && t < 100) begin @(negedge clk); t++; end
    if (!xslvo.r_valid) timeout("stall r_valid");
    d0 = xslvo.r_data;
    n0 = apb_log.size();
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!xslvo.r_valid || xslvo.r_data !== d0 || apbo.psel) stable = 1'b0;
    end
    check("stall beat held", 64'(stable), 64'd1);
    check("stall beat0 r_data", d0, 64'h0000_0000_4000_BFFF);
    check("stall apb count", 64'(apb_log.size()), 64'(n0));
    xslvi.r_ready = 1'b1;
    wait_r(2, "stall r beats");
    check("stall beat1 r_data", rq[1].data, 64'h4004_BFFB_0000_0000);
    check("stall beat1 r_last", 64'(rq[1].last), 64'd1);

    // Early wlast: SLVERR, but both beats still go out.
    apb_log.delete(); bq.delete();
    send_aw(64'h5000, 8'd1, 3'd2, BURST_INCR, 5'd8);
    send_w(64'hAAAA_0000_0000_BBBB, 8'h0F, 1'b1);
    send_w(64'hCCCC_0000_DDDD_0000, 8'hF0, 1'b1);
    wait_b("wlast b beat");
    check("wlast b_resp", 64'(bq[0].resp), 64'd2);
    check("wlast apb count", 64'(apb_log.size()), 64'd2);
    check_xfer("wlast xfer0", 0, 32'h5000, 1'b1, 32'h0000_BBBB, 4'hF);
    check_xfer("wlast xfer1", 1, 32'h5004, 1'b1, 32'hCCCC_0000, 4'hF);

    // Reset while ACCESS waits on pready: abort, no response.
    apb_log.delete(); rq.delete();
    pready_en = 1'b0;
    send_ar(64'h7000, 8'd0, 3'd2, BURST_INCR, 5'd10);
    t = 0;
    while (!apbo.penable && t < 50) begin @(negedge clk); t++; end
    check("rst access penable", 64'(apbo.penable), 64'd1);
    nrst = 1'b0;
    @(negedge clk);
    check("rst psel", 64'(apbo.psel), 64'd0);
    check("rst penable", 64'(apbo.penable), 64'd0);
    check("rst r_valid", 64'(xslvo.r_valid), 64'd0);
    check("rst ar_ready", 64'(xslvo.ar_ready), 64'd1);
    nrst = 1'b1;
    pready_en = 1'b1;
    repeat (5) @(negedge clk);
    check("rst no r beat", 64'(rq.size()), 64'd0);
    check("rst no apb xfer", 64'(apb_log.size()), 64'd0);
    send_ar(64'h1000, 8'd0, 3'd2, BURST_INCR, 5'd11);
    wait_r(1, "post-rst r beat");
    check("post-rst r_data", rq[0].data, 64'h0000_0000_1000_EFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
